// File: rtl/des_fp_out.sv
// DES output stage: forms the pre-output from the 16th-round halves, applies FP (IP^-1),
// and delivers blocks through a 2-entry in-order buffer with a completed-block counter.
module des_fp_out #(
  parameter bit SWAP_EN = 1'b1,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_l,
  input  logic [31:0]      in_r,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic [15:0]      blk_cnt
);

  logic [63:0] pre;
  logic [63:0] fp;

  assign pre = SWAP_EN ? {in_r, in_l} : {in_l, in_r};

  // FP rows alternate between two arithmetic columns: even columns 40,48,56,64 and odd
  // columns 8,16,24,32, each decreasing by one per row. DES bit n sits at index 64-n.
  generate
    for (genvar gi = 0; gi < 64; gi++) begin : g_fp
      localparam int ROW = gi / 8;
      localparam int COL = gi % 8;
      localparam int SRC = ((COL % 2) == 0) ? (40 + 4 * COL - ROW) : (4 * COL + 4 - ROW);
      assign fp[63-gi] = pre[64-SRC];
    end
  endgenerate

  logic [63:0]      data_mem [2];
  logic [TAG_W-1:0] tag_mem  [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       cnt;
  logic [1:0]       cnt_next;
  logic             push;
  logic             pop;

  assign push      = in_valid & in_ready;
  assign out_valid = (cnt != 2'd0);
  assign pop       = out_valid & out_ready;
  assign out_data  = data_mem[rd_ptr];
  assign out_tag   = tag_mem[rd_ptr];

  always_comb begin
    cnt_next = cnt;
    if (push && !pop)
      cnt_next = cnt + 2'd1;
    else if (pop && !push)
      cnt_next = cnt - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_mem[0] <= '0;
      data_mem[1] <= '0;
      tag_mem[0]  <= '0;
      tag_mem[1]  <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      cnt         <= 2'd0;
      in_ready    <= 1'b0;
      blk_cnt     <= 16'd0;
    end else begin
      if (push) begin
        data_mem[wr_ptr] <= fp;
        tag_mem[wr_ptr]  <= in_tag;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr  <= ~rd_ptr;
        blk_cnt <= blk_cnt + 16'd1;
      end
      cnt      <= cnt_next;
      // Registered ready keeps out_ready off any combinational path to the input side.
      in_ready <= (cnt_next != 2'd2);
    end
  end

endmodule

// File: tb/tb_des_fp_out.sv
// Directed bench for des_fp_out: FP vectors from a table, then backpressure, streaming,
// mid-operation reset and counter wrap sequences.
module tb_des_fp_out;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_l = '0;
  logic [31:0] in_r = '0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic [3:0]  out_tag;
  logic [15:0] blk_cnt;

  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic [31:0] b_in_l = '0;
  logic [31:0] b_in_r = '0;
  logic [3:0]  b_in_tag = '0;
  logic        b_out_valid;
  logic        b_out_ready = 1'b1;
  logic [63:0] b_out_data;
  logic [3:0]  b_out_tag;
  logic [15:0] b_blk_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  des_fp_out #(.SWAP_EN(1'b1), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_l(in_l), .in_r(in_r), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag), .blk_cnt(blk_cnt)
  );

  des_fp_out #(.SWAP_EN(1'b0), .TAG_W(4)) dut_noswap (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_l(b_in_l), .in_r(b_in_r), .in_tag(b_in_tag), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .out_tag(b_out_tag), .blk_cnt(b_blk_cnt)
  );

  typedef struct {
    logic [31:0] l;
    logic [31:0] r;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input logic [3:0] tag);
    in_l     = vecs[k].l;
    in_r     = vecs[k].r;
    in_tag   = tag;
    in_valid = 1'b1;
  endtask

  initial begin
    logic [15:0] cnt_exp;
    logic        ready_ok;
    int          cycles;

    vecs[0] = '{32'h43423234, 32'h0A4CD995, 64'h85E813540F0AB405};
    vecs[1] = '{32'h00000000, 32'h00000000, 64'h0000000000000000};
    vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF};
    vecs[3] = '{32'h00000000, 32'h80000000, 64'h0000000000000040};
    vecs[4] = '{32'h00000001, 32'h00000000, 64'h0200000000000000};
    vecs[5] = '{32'h01000000, 32'h00000000, 64'h8000000000000000};
    vecs[6] = '{32'hF0AAF0AA, 32'hCC00CCFF, 64'h0123456789ABCDEF};

    // Reset state
    #12;
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst in_ready", 64'(in_ready), 64'd0);
    check("rst blk_cnt", 64'(blk_cnt), 64'd0);
    check("rst out_data", out_data, 64'd0);
    check("rst out_tag", 64'(out_tag), 64'd0);
    rst_n = 1'b1;
    tick();
    check("in_ready after release", 64'(in_ready), 64'd1);

    // Table-driven FP vectors, one block at a time with out_ready high
    out_ready = 1'b1;
    cnt_exp = 16'd0;
    for (int k = 0; k < 7; k++) begin
      drive(k, 4'(k + 1));
      tick();
      in_valid = 1'b0;
      check($sformatf("vec%0d out_valid", k), 64'(out_valid), 64'd1);
      check($sformatf("vec%0d out_data", k), out_data, vecs[k].exp);
      check($sformatf("vec%0d out_tag", k), 64'(out_tag), 64'(k + 1));
      tick();
      cnt_exp++;
      check($sformatf("vec%0d blk_cnt", k), 64'(blk_cnt), 64'(cnt_exp));
      check($sformatf("vec%0d drained", k), 64'(out_valid), 64'd0);
    end

    // SWAP_EN=0: L||R is taken as-is, so IP(0x0123456789ABCDEF) inverts back
    b_in_l = 32'hCC00CCFF; b_in_r = 32'hF0AAF0AA; b_in_tag = 4'hA; b_in_valid = 1'b1;
    tick();
    b_in_valid = 1'b0;
    check("noswap inverse IP", b_out_data, 64'h0123456789ABCDEF);
    check("noswap tag", 64'(b_out_tag), 64'hA);
    b_in_l = 32'h80000000; b_in_r = 32'h00000000; b_in_valid = 1'b1;
    tick();
    b_in_valid = 1'b0;
    check("noswap bit1", b_out_data, 64'h0000000000000040);
    tick();
    check("noswap blk_cnt", 64'(b_blk_cnt), 64'd2);

    // Backpressure: A, B fill the buffer, C is refused until a pop frees space
    out_ready = 1'b0;
    drive(0, 4'd1);
    tick();
    drive(6, 4'd2);
    tick();
    check("bp in_ready low when full", 64'(in_ready), 64'd0);
    check("bp head A", out_data, vecs[0].exp);
    drive(5, 4'd3);
    tick();
    check("bp C refused, head still A", out_data, vecs[0].exp);
    check("bp head tag 1", 64'(out_tag), 64'd1);
    check("bp still full", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    tick();
    check("bp in_ready after first pop", 64'(in_ready), 64'd1);
    check("bp second B", out_data, vecs[6].exp);
    check("bp second tag 2", 64'(out_tag), 64'd2);
    tick();
    in_valid = 1'b0;
    check("bp third C", out_data, vecs[5].exp);
    check("bp third tag 3", 64'(out_tag), 64'd3);
    tick();
    cnt_exp = cnt_exp + 16'd3;
    check("bp blk_cnt +3", 64'(blk_cnt), 64'(cnt_exp));
    check("bp drained", 64'(out_valid), 64'd0);

    // Simultaneous push and pop at occupancy one
    out_ready = 1'b0;
    drive(0, 4'd0);
    tick();
    out_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      drive(k % 7, 4'(k));
      check($sformatf("pp%0d in_ready", k), 64'(in_ready), 64'd1);
      check($sformatf("pp%0d out_data", k), out_data, vecs[(k - 1) % 7].exp);
      check($sformatf("pp%0d out_tag", k), 64'(out_tag), 64'(k - 1));
      tick();
    end
    in_valid = 1'b0;
    check("pp last block", out_data, vecs[10 % 7].exp);
    tick();
    cnt_exp = cnt_exp + 16'd11;
    check("pp blk_cnt", 64'(blk_cnt), 64'(cnt_exp));
    check("pp drained", 64'(out_valid), 64'd0);

    // Reset mid-operation with a full buffer
    out_ready = 1'b0;
    drive(0, 4'd5);
    tick();
    drive(2, 4'd6);
    tick();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid rst out_valid", 64'(out_valid), 64'd0);
    check("mid rst in_ready", 64'(in_ready), 64'd0);
    check("mid rst blk_cnt", 64'(blk_cnt), 64'd0);
    check("mid rst out_data", out_data, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("mid rst in_ready after release", 64'(in_ready), 64'd1);
    check("mid rst nothing emitted", 64'(out_valid), 64'd0);
    drive(4, 4'd7);
    tick();
    in_valid = 1'b0;
    check("mid rst first new block", out_data, vecs[4].exp);
    check("mid rst new tag", 64'(out_tag), 64'd7);

    // Stream until blk_cnt reaches 0xFFFF, then one more pop wraps it
    out_ready = 1'b1;
    drive(3, 4'd9);
    ready_ok = 1'b1;
    cycles = 0;
    while (blk_cnt != 16'hFFFF && cycles < 70000) begin
      tick();
      if (!in_ready || !out_valid) ready_ok = 1'b0;
      cycles++;
    end
    in_valid = 1'b0;
    check("stream reached 0xFFFF", 64'(blk_cnt), 64'hFFFF);
    check("stream in_ready/out_valid steady", 64'(ready_ok), 64'd1);
    check("stream data", out_data, vecs[3].exp);
    tick();
    check("wrap blk_cnt", 64'(blk_cnt), 64'd0);
    check("wrap drained", 64'(out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
